// File: rtl/phy_pkg.sv
// Shared PHY TX constants: word width, ordered-set symbols, scheduler states and lane modes.
package phy_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] SKIP_WORD = 32'hBC1C1C1C;
  localparam logic [DATA_W-1:0] PAD_WORD  = 32'hF7F7F7F7;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    PAD,
    SKIP0,
    SKIP1
  } sched_state_t;

  typedef enum logic {
    LANE_X1 = 1'b0,
    LANE_X2 = 1'b1
  } lane_mode_t;

endpackage

// File: rtl/skip_interval_counter.sv
// Saturating count of accepted data words since the last SKIP ordered set.
module skip_interval_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_2f,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic at_limit
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_2f) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_W'(LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_limit = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/stripe_sched_ctrl.sv
// Lane sequencer ahead of demux_striping: maps words to lanes, pads odd x2 bursts
// and inserts SKIP ordered sets on every active lane after SKIP_INTERVAL data words.
module stripe_sched_ctrl
  import phy_pkg::*;
#(
  parameter int unsigned SKIP_INTERVAL = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              lane_mode,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_input,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              skip_active
);

  sched_state_t state;
  logic         ptr;
  logic         mode;
  logic         at_limit;
  logic         skip_due;
  logic         accept;
  logic         eff_mode;
  logic         cnt_clear;

  // SKIP may only start on a lane-pair boundary
  assign skip_due  = at_limit && !ptr;
  assign in_ready  = !reset && ((state == IDLE) || (state == STREAM)) && !skip_due;
  assign accept    = valid_in && in_ready;
  assign eff_mode  = (state == IDLE) ? lane_mode : mode;
  assign cnt_clear = (state == SKIP1) || ((state == SKIP0) && (mode == LANE_X1));

  skip_interval_counter #(
    .LIMIT (SKIP_INTERVAL)
  ) u_skip_cnt (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .inc      (accept),
    .clear    (cnt_clear),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      mode        <= LANE_X1;
      out_valid   <= 1'b0;
      out_sel     <= 1'b0;
      out_data    <= '0;
      skip_active <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      skip_active <= 1'b0;

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= data_input;
        out_sel   <= ptr;
        ptr       <= (eff_mode == LANE_X2) ? ~ptr : 1'b0;
      end

      case (state)
        IDLE: begin
          mode <= lane_mode;
          if (skip_due) begin
            state <= SKIP0;
          end else if (accept) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (skip_due) begin
            state <= SKIP0;
          end else if (!valid_in) begin
            state <= ptr ? PAD : IDLE;
          end
        end
        PAD: begin
          out_valid <= 1'b1;
          out_sel   <= 1'b1;
          out_data  <= PAD_WORD;
          ptr       <= 1'b0;
          state     <= IDLE;
        end
        SKIP0: begin
          out_valid   <= 1'b1;
          out_sel     <= 1'b0;
          out_data    <= SKIP_WORD;
          skip_active <= 1'b1;
          state       <= (mode == LANE_X2) ? SKIP1 : IDLE;
        end
        SKIP1: begin
          out_valid   <= 1'b1;
          out_sel     <= 1'b1;
          out_data    <= SKIP_WORD;
          skip_active <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
